// File: rtl/stack_ctrl.sv
// stack_ctrl: downward-growing stack controller in front of a dual-port
// scratch RAM (X port). It turns single-cycle PUSH/POP requests into RAM
// accesses, registers popped data and can sweep the whole RAM to zero.
// Optional feature macro: STACK_GUARD_EN. When defined, overflow and
// underflow are blocked and latch a sticky ERR flag. When undefined, pushes
// wrap and overwrite the oldest entry, pops on empty read through, and ERR
// stays 0.
module stack_ctrl #(
  parameter int ADDR_SIZE = 5,
  parameter int DATA_SIZE = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 PUSH,
  input  logic                 POP,
  input  logic                 CLEAR,
  input  logic [DATA_SIZE-1:0] DIN,
  input  logic [DATA_SIZE-1:0] RAM_DX,
  output logic [ADDR_SIZE-1:0] RAM_ADR,
  output logic [DATA_SIZE-1:0] RAM_DIN,
  output logic                 RAM_WE,
  output logic [DATA_SIZE-1:0] DOUT,
  output logic                 POP_VALID,
  output logic [ADDR_SIZE-1:0] SP,
  output logic                 EMPTY,
  output logic                 FULL,
  output logic                 BUSY,
  output logic                 ERR
);

  localparam logic [ADDR_SIZE:0]   DEPTH   = {1'b1, {ADDR_SIZE{1'b0}}};
  localparam logic [ADDR_SIZE-1:0] IDX_MAX = {ADDR_SIZE{1'b1}};

  typedef enum logic {S_IDLE = 1'b0, S_SWEEP = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [ADDR_SIZE-1:0] sp_q, sp_d;
  logic [ADDR_SIZE:0]   count_q, count_d;
  logic [ADDR_SIZE-1:0] idx_q, idx_d;
  logic [DATA_SIZE-1:0] dout_q, dout_d;
  logic                 pop_valid_q, pop_valid_d;
  logic                 err_q, err_d;

  logic idle;
  logic clr_req;
  logic push_req;
  logic pop_req;
  logic push_acc;
  logic pop_acc;
  logic guard_err;
  logic sweep_last;

  assign EMPTY = (count_q == '0);
  assign FULL  = (count_q == DEPTH);

  // Request arbitration: CLEAR beats PUSH beats POP, and only in IDLE.
  assign idle       = (state_q == S_IDLE);
  assign clr_req    = idle & CLEAR;
  assign push_req   = idle & ~CLEAR & PUSH;
  assign pop_req    = idle & ~CLEAR & ~PUSH & POP;
  assign sweep_last = (state_q == S_SWEEP) && (idx_q == IDX_MAX);

`ifdef STACK_GUARD_EN
  assign push_acc  = push_req & ~FULL;
  assign pop_acc   = pop_req & ~EMPTY;
  assign guard_err = (push_req & FULL) | (pop_req & EMPTY);
`else
  assign push_acc  = push_req;
  assign pop_acc   = pop_req;
  assign guard_err = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: enter SWEEP on CLEAR, leave after the last word is written.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (clr_req)    state_d = S_SWEEP;
      S_SWEEP: if (sweep_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: RAM port drive; reset suppresses any write in its cycle.
  always_comb begin
    RAM_ADR = sp_q;
    RAM_DIN = DIN;
    RAM_WE  = 1'b0;
    BUSY    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (push_acc) begin
          RAM_ADR = sp_q - 1'b1;
          RAM_WE  = ~RST;
        end
      end
      S_SWEEP: begin
        RAM_ADR = idx_q;
        RAM_DIN = '0;
        RAM_WE  = ~RST;
        BUSY    = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next state: pointer, occupancy, sweep index, popped data, error.
  always_comb begin
    sp_d        = sp_q;
    count_d     = count_q;
    idx_d       = idx_q;
    dout_d      = dout_q;
    pop_valid_d = 1'b0;
    err_d       = err_q | guard_err;
    if (clr_req) begin
      idx_d = '0;
    end else if (state_q == S_SWEEP) begin
      idx_d = idx_q + 1'b1;
      if (sweep_last) begin
        sp_d    = '0;
        count_d = '0;
        err_d   = 1'b0;
      end
    end else if (push_acc) begin
      sp_d = sp_q - 1'b1;
      // Saturate: a wrapping push replaces the oldest entry.
      if (count_q != DEPTH) count_d = count_q + 1'b1;
    end else if (pop_acc) begin
      sp_d        = sp_q + 1'b1;
      dout_d      = RAM_DX;
      pop_valid_d = 1'b1;
      if (count_q != '0) count_d = count_q - 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sp_q        <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      dout_q      <= '0;
      pop_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      dout_q      <= dout_d;
      pop_valid_q <= pop_valid_d;
      err_q       <= err_d;
    end
  end

  assign SP        = sp_q;
  assign DOUT      = dout_q;
  assign POP_VALID = pop_valid_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed testbench for stack_ctrl with a behavioural model of the
// scratch RAM (synchronous write, asynchronous read) on the X port.
module tb_stack_ctrl;
  localparam int AW = 5;
  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST, PUSH, POP, CLEAR;
  logic [DW-1:0] DIN;
  logic [DW-1:0] RAM_DX;
  logic [AW-1:0] RAM_ADR;
  logic [DW-1:0] RAM_DIN;
  logic          RAM_WE;
  logic [DW-1:0] DOUT;
  logic          POP_VALID;
  logic [AW-1:0] SP;
  logic          EMPTY, FULL, BUSY, ERR;

  logic [DW-1:0] mem [0:31];

  int vecs = 0;
  int miss = 0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (RAM_WE) mem[RAM_ADR] <= RAM_DIN;
  assign RAM_DX = mem[RAM_ADR];

  stack_ctrl #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) dut (
    .CLK(CLK), .RST(RST), .PUSH(PUSH), .POP(POP), .CLEAR(CLEAR), .DIN(DIN),
    .RAM_DX(RAM_DX), .RAM_ADR(RAM_ADR), .RAM_DIN(RAM_DIN), .RAM_WE(RAM_WE),
    .DOUT(DOUT), .POP_VALID(POP_VALID), .SP(SP), .EMPTY(EMPTY), .FULL(FULL),
    .BUSY(BUSY), .ERR(ERR)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    RST = 1'b1; PUSH = 1'b0; POP = 1'b0; CLEAR = 1'b0; DIN = '0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    vecs++; if (SP !== 5'd0) begin miss++; $display("FAIL reset_sp got %h want 00", SP); end
    vecs++; if (EMPTY !== 1'b1 || FULL !== 1'b0 || BUSY !== 1'b0) begin miss++; $display("FAIL reset_flags got E%b F%b B%b want E1 F0 B0", EMPTY, FULL, BUSY); end
    vecs++; if (ERR !== 1'b0 || POP_VALID !== 1'b0) begin miss++; $display("FAIL reset_err_pv got %b%b want 00", ERR, POP_VALID); end
    vecs++; if (DOUT !== 8'h00) begin miss++; $display("FAIL reset_dout got %h want 00", DOUT); end
  endtask

  task automatic test_push3;
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      PUSH = 1'b1; DIN = vals[i];
      #1;
      vecs++; if (RAM_ADR !== 5'(31 - i) || RAM_WE !== 1'b1 || RAM_DIN !== vals[i]) begin miss++; $display("FAIL push_port%0d got adr %0d we %b din %h want adr %0d we 1 din %h", i, RAM_ADR, RAM_WE, RAM_DIN, 31 - i, vals[i]); end
      tick();
    end
    PUSH = 1'b0;
    vecs++; if (SP !== 5'd29 || EMPTY !== 1'b0) begin miss++; $display("FAIL push3_sp got %0d E%b want 29 E0", SP, EMPTY); end
    vecs++; if (mem[31] !== 8'h11 || mem[30] !== 8'h22 || mem[29] !== 8'h33) begin miss++; $display("FAIL push3_mem got %h %h %h want 11 22 33", mem[31], mem[30], mem[29]); end
  endtask

  task automatic test_pop3;
    logic [7:0] exp [3];
    exp[0] = 8'h33; exp[1] = 8'h22; exp[2] = 8'h11;
    POP = 1'b1;
    #1;
    vecs++; if (RAM_ADR !== 5'd29 || RAM_WE !== 1'b0 || POP_VALID !== 1'b0) begin miss++; $display("FAIL pop_port got adr %0d we %b pv %b want 29 0 0", RAM_ADR, RAM_WE, POP_VALID); end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) POP = 1'b0;
      vecs++; if (POP_VALID !== 1'b1 || DOUT !== exp[i]) begin miss++; $display("FAIL pop%0d got pv %b dout %h want pv 1 dout %h", i, POP_VALID, DOUT, exp[i]); end
    end
    vecs++; if (SP !== 5'd0 || EMPTY !== 1'b1) begin miss++; $display("FAIL pop3_sp got %0d E%b want 0 E1", SP, EMPTY); end
    tick();
    vecs++; if (POP_VALID !== 1'b0 || DOUT !== 8'h11) begin miss++; $display("FAIL pop_idle got pv %b dout %h want 0 11", POP_VALID, DOUT); end
  endtask

  task automatic test_push_pop_same;
    PUSH = 1'b1; POP = 1'b1; DIN = 8'hAA;
    #1;
    vecs++; if (RAM_ADR !== 5'd31 || RAM_WE !== 1'b1) begin miss++; $display("FAIL pp_port got adr %0d we %b want 31 1", RAM_ADR, RAM_WE); end
    tick();
    PUSH = 1'b0; POP = 1'b0;
    vecs++; if (mem[31] !== 8'hAA || SP !== 5'd31 || POP_VALID !== 1'b0 || ERR !== 1'b0) begin miss++; $display("FAIL pp_result got mem %h sp %0d pv %b err %b want AA 31 0 0", mem[31], SP, POP_VALID, ERR); end
    POP = 1'b1;
    tick();
    POP = 1'b0;
    vecs++; if (DOUT !== 8'hAA || SP !== 5'd0 || EMPTY !== 1'b1) begin miss++; $display("FAIL pp_popback got dout %h sp %0d E%b want AA 0 1", DOUT, SP, EMPTY); end
  endtask

  task automatic test_full;
    for (int i = 0; i < 32; i++) begin
      PUSH = 1'b1; DIN = 8'(i + 1);
      tick();
    end
    PUSH = 1'b0;
    vecs++; if (FULL !== 1'b1 || SP !== 5'd0 || EMPTY !== 1'b0) begin miss++; $display("FAIL full_flag got F%b sp %0d E%b want F1 0 E0", FULL, SP, EMPTY); end
    PUSH = 1'b1; DIN = 8'h5A;
    #1;
`ifdef STACK_GUARD_EN
    vecs++; if (RAM_WE !== 1'b0) begin miss++; $display("FAIL ovf_we got %b want 0", RAM_WE); end
    tick();
    PUSH = 1'b0;
    vecs++; if (mem[31] !== 8'h01 || ERR !== 1'b1 || SP !== 5'd0 || FULL !== 1'b1) begin miss++; $display("FAIL ovf_guard got mem %h err %b sp %0d F%b want 01 1 0 1", mem[31], ERR, SP, FULL); end
`else
    vecs++; if (RAM_WE !== 1'b1 || RAM_ADR !== 5'd31) begin miss++; $display("FAIL ovf_port got we %b adr %0d want 1 31", RAM_WE, RAM_ADR); end
    tick();
    PUSH = 1'b0;
    vecs++; if (mem[31] !== 8'h5A || ERR !== 1'b0 || SP !== 5'd31 || FULL !== 1'b1) begin miss++; $display("FAIL ovf_wrap got mem %h err %b sp %0d F%b want 5A 0 31 1", mem[31], ERR, SP, FULL); end
`endif
  endtask

  task automatic test_clear;
    int n;
    int bad;
    do_reset();
    POP = 1'b1;
    tick();
    POP = 1'b0;
`ifdef STACK_GUARD_EN
    vecs++; if (POP_VALID !== 1'b0 || ERR !== 1'b1 || SP !== 5'd0 || DOUT !== 8'h00) begin miss++; $display("FAIL udf_guard got pv %b err %b sp %0d dout %h want 0 1 0 00", POP_VALID, ERR, SP, DOUT); end
`else
    vecs++; if (POP_VALID !== 1'b1 || ERR !== 1'b0 || SP !== 5'd1 || EMPTY !== 1'b1 || DOUT !== 8'h20) begin miss++; $display("FAIL udf_wrap got pv %b err %b sp %0d E%b dout %h want 1 0 1 1 20", POP_VALID, ERR, SP, EMPTY, DOUT); end
`endif
    for (int i = 0; i < 5; i++) begin
      PUSH = 1'b1; DIN = 8'(8'h40 + i);
      tick();
    end
    PUSH = 1'b0;
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    PUSH = 1'b1; DIN = 8'h77;
    #1;
    vecs++; if (BUSY !== 1'b1 || RAM_ADR !== 5'd0 || RAM_DIN !== 8'h00 || RAM_WE !== 1'b1) begin miss++; $display("FAIL sweep_port got B%b adr %0d din %h we %b want 1 0 00 1", BUSY, RAM_ADR, RAM_DIN, RAM_WE); end
    n = 0;
    while (BUSY === 1'b1 && n < 64) begin
      n++;
      if (n == 4) PUSH = 1'b0;
      tick();
    end
    vecs++; if (n !== 32) begin miss++; $display("FAIL busy_len got %0d want 32", n); end
    bad = 0;
    for (int a = 0; a < 32; a++) if (mem[a] !== 8'h00) bad++;
    vecs++; if (bad !== 0) begin miss++; $display("FAIL clear_mem got %0d nonzero words want 0", bad); end
    vecs++; if (SP !== 5'd0 || EMPTY !== 1'b1 || ERR !== 1'b0 || FULL !== 1'b0) begin miss++; $display("FAIL clear_state got sp %0d E%b err %b F%b want 0 1 0 0", SP, EMPTY, ERR, FULL); end
    PUSH = 1'b1; DIN = 8'h3C;
    #1;
    vecs++; if (RAM_WE !== 1'b1 || RAM_ADR !== 5'd31) begin miss++; $display("FAIL post_clear_port got we %b adr %0d want 1 31", RAM_WE, RAM_ADR); end
    tick();
    PUSH = 1'b0;
    vecs++; if (SP !== 5'd31 || mem[31] !== 8'h3C) begin miss++; $display("FAIL post_clear_push got sp %0d mem %h want 31 3C", SP, mem[31]); end
  endtask

  task automatic test_rst_sweep;
    int bad;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      PUSH = 1'b1; DIN = 8'(8'h80 + (31 - i));
      tick();
    end
    PUSH = 1'b0;
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    repeat (10) tick();
    vecs++; if (BUSY !== 1'b1 || RAM_ADR !== 5'd10) begin miss++; $display("FAIL sweep10 got B%b adr %0d want 1 10", BUSY, RAM_ADR); end
    RST = 1'b1;
    #1;
    vecs++; if (RAM_WE !== 1'b0) begin miss++; $display("FAIL rst_we got %b want 0", RAM_WE); end
    tick();
    RST = 1'b0;
    vecs++; if (BUSY !== 1'b0 || SP !== 5'd0 || EMPTY !== 1'b1) begin miss++; $display("FAIL rst_abort got B%b sp %0d E%b want 0 0 1", BUSY, SP, EMPTY); end
    bad = 0;
    for (int a = 0; a < 10; a++) if (mem[a] !== 8'h00) bad++;
    vecs++; if (bad !== 0) begin miss++; $display("FAIL partial_zero got %0d bad words want 0", bad); end
    bad = 0;
    for (int a = 10; a < 32; a++) if (mem[a] !== 8'(8'h80 + a)) bad++;
    vecs++; if (bad !== 0) begin miss++; $display("FAIL partial_keep got %0d bad words want 0", bad); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; PUSH = 1'b0; POP = 1'b0; CLEAR = 1'b0; DIN = '0;
    test_reset();
    test_push3();
    test_pop3();
    test_push_pop_same();
    test_full();
    test_clear();
    test_rst_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
